// File: rtl/control_pipe.sv
// Control-word pipeline (ID/EX, EX/MEM, MEM/WB) with load-use stall,
// branch flush, EX forwarding selects and a saturating stall counter.
module control_pipe #(
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       RegDst,
    input  logic                       ALUSrc,
    input  logic                       MemtoReg,
    input  logic                       RegWrite,
    input  logic                       MemRead,
    input  logic                       MemWrite,
    input  logic                       BranchNE,
    input  logic                       BranchEQ,
    input  logic [5:0]                 ALUOp,
    input  logic [4:0]                 ID_Rs,
    input  logic [4:0]                 ID_Rt,
    input  logic [4:0]                 ID_Rd,
    input  logic                       BranchTaken,
    output logic                       PCWrite,
    output logic                       IFIDWrite,
    output logic                       IFIDFlush,
    output logic                       EX_RegDst,
    output logic                       EX_ALUSrc,
    output logic                       EX_BranchNE,
    output logic                       EX_BranchEQ,
    output logic [5:0]                 EX_ALUOp,
    output logic [4:0]                 EX_Rs,
    output logic [4:0]                 EX_Rt,
    output logic                       MEM_MemRead,
    output logic                       MEM_MemWrite,
    output logic [4:0]                 MEM_WriteReg,
    output logic                       WB_RegWrite,
    output logic                       WB_MemtoReg,
    output logic [4:0]                 WB_WriteReg,
    output logic [1:0]                 ForwardA,
    output logic [1:0]                 ForwardB,
    output logic [STALL_CNT_WIDTH-1:0] StallCount
);

    logic                       r_ex_regdst;
    logic                       r_ex_alusrc;
    logic                       r_ex_memtoreg;
    logic                       r_ex_regwrite;
    logic                       r_ex_memread;
    logic                       r_ex_memwrite;
    logic                       r_ex_bne;
    logic                       r_ex_beq;
    logic [5:0]                 r_ex_aluop;
    logic [4:0]                 r_ex_rs;
    logic [4:0]                 r_ex_rt;
    logic [4:0]                 r_ex_rd;

    logic                       r_mem_memread;
    logic                       r_mem_memwrite;
    logic                       r_mem_memtoreg;
    logic                       r_mem_regwrite;
    logic [4:0]                 r_mem_writereg;

    logic                       r_wb_regwrite;
    logic                       r_wb_memtoreg;
    logic [4:0]                 r_wb_writereg;

    logic [STALL_CNT_WIDTH-1:0] r_stall_cnt;

    logic                       w_load_use;
    logic                       w_stall;
    logic                       w_bubble;
    logic [4:0]                 w_ex_writereg;

    assign w_load_use = r_ex_memread && (r_ex_rt != 5'd0)
                        && ((r_ex_rt == ID_Rs) || (r_ex_rt == ID_Rt));
    // A taken branch overrides a simultaneous load-use stall.
    assign w_stall    = w_load_use && !BranchTaken;
    assign w_bubble   = w_load_use || BranchTaken;
    assign w_ex_writereg = r_ex_regdst ? r_ex_rd : r_ex_rt;

    assign PCWrite   = reset || !w_stall;
    assign IFIDWrite = reset || !w_stall;
    assign IFIDFlush = !reset && BranchTaken;

    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        if (r_mem_regwrite && (r_mem_writereg != 5'd0)
            && (r_mem_writereg == src))
            return 2'b10;
        else if (r_wb_regwrite && (r_wb_writereg != 5'd0)
                 && (r_wb_writereg == src))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign ForwardA = fwd_sel(r_ex_rs);
    assign ForwardB = fwd_sel(r_ex_rt);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ex_regdst   <= 1'b0;
            r_ex_alusrc   <= 1'b0;
            r_ex_memtoreg <= 1'b0;
            r_ex_regwrite <= 1'b0;
            r_ex_memread  <= 1'b0;
            r_ex_memwrite <= 1'b0;
            r_ex_bne      <= 1'b0;
            r_ex_beq      <= 1'b0;
            r_ex_aluop    <= 6'd0;
            r_ex_rs       <= 5'd0;
            r_ex_rt       <= 5'd0;
            r_ex_rd       <= 5'd0;
        end else begin
            r_ex_rs <= ID_Rs;
            r_ex_rt <= ID_Rt;
            r_ex_rd <= ID_Rd;
            if (w_bubble) begin
                r_ex_regdst   <= 1'b0;
                r_ex_alusrc   <= 1'b0;
                r_ex_memtoreg <= 1'b0;
                r_ex_regwrite <= 1'b0;
                r_ex_memread  <= 1'b0;
                r_ex_memwrite <= 1'b0;
                r_ex_bne      <= 1'b0;
                r_ex_beq      <= 1'b0;
                r_ex_aluop    <= 6'd0;
            end else begin
                r_ex_regdst   <= RegDst;
                r_ex_alusrc   <= ALUSrc;
                r_ex_memtoreg <= MemtoReg;
                r_ex_regwrite <= RegWrite;
                r_ex_memread  <= MemRead;
                r_ex_memwrite <= MemWrite;
                r_ex_bne      <= BranchNE;
                r_ex_beq      <= BranchEQ;
                r_ex_aluop    <= ALUOp;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem_memread  <= 1'b0;
            r_mem_memwrite <= 1'b0;
            r_mem_memtoreg <= 1'b0;
            r_mem_regwrite <= 1'b0;
            r_mem_writereg <= 5'd0;
            r_wb_regwrite  <= 1'b0;
            r_wb_memtoreg  <= 1'b0;
            r_wb_writereg  <= 5'd0;
        end else begin
            r_mem_memread  <= r_ex_memread;
            r_mem_memwrite <= r_ex_memwrite;
            r_mem_memtoreg <= r_ex_memtoreg;
            r_mem_regwrite <= r_ex_regwrite;
            r_mem_writereg <= w_ex_writereg;
            r_wb_regwrite  <= r_mem_regwrite;
            r_wb_memtoreg  <= r_mem_memtoreg;
            r_wb_writereg  <= r_mem_writereg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_stall_cnt <= '0;
        else if (w_stall && !(&r_stall_cnt))
            r_stall_cnt <= r_stall_cnt + STALL_CNT_WIDTH'(1);
    end

    assign EX_RegDst    = r_ex_regdst;
    assign EX_ALUSrc    = r_ex_alusrc;
    assign EX_BranchNE  = r_ex_bne;
    assign EX_BranchEQ  = r_ex_beq;
    assign EX_ALUOp     = r_ex_aluop;
    assign EX_Rs        = r_ex_rs;
    assign EX_Rt        = r_ex_rt;
    assign MEM_MemRead  = r_mem_memread;
    assign MEM_MemWrite = r_mem_memwrite;
    assign MEM_WriteReg = r_mem_writereg;
    assign WB_RegWrite  = r_wb_regwrite;
    assign WB_MemtoReg  = r_wb_memtoreg;
    assign WB_WriteReg  = r_wb_writereg;
    assign StallCount   = r_stall_cnt;

endmodule

// File: tb/tb_control_pipe.sv
// Randomized scoreboard bench for control_pipe against an
// instruction-level pipeline model.
module tb_control_pipe;

    localparam int W = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         RegDst = 0, ALUSrc = 0, MemtoReg = 0, RegWrite = 0;
    logic         MemRead = 0, MemWrite = 0, BranchNE = 0, BranchEQ = 0;
    logic [5:0]   ALUOp = '0;
    logic [4:0]   ID_Rs = '0, ID_Rt = '0, ID_Rd = '0;
    logic         BranchTaken = 1'b0;
    logic         PCWrite, IFIDWrite, IFIDFlush;
    logic         EX_RegDst, EX_ALUSrc, EX_BranchNE, EX_BranchEQ;
    logic [5:0]   EX_ALUOp;
    logic [4:0]   EX_Rs, EX_Rt;
    logic         MEM_MemRead, MEM_MemWrite;
    logic [4:0]   MEM_WriteReg;
    logic         WB_RegWrite, WB_MemtoReg;
    logic [4:0]   WB_WriteReg;
    logic [1:0]   ForwardA, ForwardB;
    logic [W-1:0] StallCount;

    control_pipe #(.STALL_CNT_WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .RegDst(RegDst), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .BranchNE(BranchNE), .BranchEQ(BranchEQ), .ALUOp(ALUOp),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd),
        .BranchTaken(BranchTaken),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush),
        .EX_RegDst(EX_RegDst), .EX_ALUSrc(EX_ALUSrc),
        .EX_BranchNE(EX_BranchNE), .EX_BranchEQ(EX_BranchEQ),
        .EX_ALUOp(EX_ALUOp), .EX_Rs(EX_Rs), .EX_Rt(EX_Rt),
        .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
        .MEM_WriteReg(MEM_WriteReg),
        .WB_RegWrite(WB_RegWrite), .WB_MemtoReg(WB_MemtoReg),
        .WB_WriteReg(WB_WriteReg),
        .ForwardA(ForwardA), .ForwardB(ForwardB),
        .StallCount(StallCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       regdst, alusrc, memtoreg, regwrite;
        bit       memread, memwrite, bne, beq;
        bit [5:0] aluop;
        bit [4:0] rs, rt, rd;
    } ins_t;

    typedef struct {
        logic [19:0] ex;
        logic [6:0]  mem;
        logic [6:0]  wb;
        logic [2:0]  hz;
        logic [3:0]  fwd;
        logic [W-1:0] sc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Instructions occupying each stage, plus the stall tally.
    ins_t m_ex, m_mem, m_wb;
    int   m_sc;

    function automatic bit [4:0] dest(input ins_t i);
        return i.regdst ? i.rd : i.rt;
    endfunction

    function automatic bit [1:0] fsel(input bit [4:0] r);
        if (m_mem.regwrite && dest(m_mem) != 0 && dest(m_mem) == r)
            return 2'b10;
        if (m_wb.regwrite && dest(m_wb) != 0 && dest(m_wb) == r)
            return 2'b01;
        return 2'b00;
    endfunction

    function automatic ins_t nop();
        ins_t z;
        z = '{default: 0};
        return z;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("ex", 32'({EX_RegDst, EX_ALUSrc, EX_BranchNE, EX_BranchEQ,
                           EX_ALUOp, EX_Rs, EX_Rt}), 32'(e.ex));
            chk("mem", 32'({MEM_MemRead, MEM_MemWrite, MEM_WriteReg}),
                32'(e.mem));
            chk("wb", 32'({WB_RegWrite, WB_MemtoReg, WB_WriteReg}),
                32'(e.wb));
            chk("hazard", 32'({PCWrite, IFIDWrite, IFIDFlush}), 32'(e.hz));
            chk("forward", 32'({ForwardA, ForwardB}), 32'(e.fwd));
            chk("stallcnt", 32'(StallCount), 32'(e.sc));
        end
    end

    task automatic step(input ins_t d, input bit bt, input bit rst,
                        output bit stalled);
        exp_t e;
        bit   lu;
        @(posedge clk);
        #2;
        reset = rst;
        RegDst = d.regdst; ALUSrc = d.alusrc; MemtoReg = d.memtoreg;
        RegWrite = d.regwrite; MemRead = d.memread; MemWrite = d.memwrite;
        BranchNE = d.bne; BranchEQ = d.beq; ALUOp = d.aluop;
        ID_Rs = d.rs; ID_Rt = d.rt; ID_Rd = d.rd;
        BranchTaken = bt;
        stalled = 1'b0;
        if (rst) begin
            m_ex = nop(); m_mem = nop(); m_wb = nop(); m_sc = 0;
            e.ex = '0; e.mem = '0; e.wb = '0; e.sc = '0;
            e.hz = 3'b110; e.fwd = 4'b0000;
            q.push_back(e);
        end else begin
            e.ex  = {m_ex.regdst, m_ex.alusrc, m_ex.bne, m_ex.beq,
                     m_ex.aluop, m_ex.rs, m_ex.rt};
            e.mem = {m_mem.memread, m_mem.memwrite, dest(m_mem)};
            e.wb  = {m_wb.regwrite, m_wb.memtoreg, dest(m_wb)};
            e.sc  = W'(m_sc);
            lu = m_ex.memread && m_ex.rt != 0
                 && (m_ex.rt == d.rs || m_ex.rt == d.rt);
            stalled = lu && !bt;
            e.hz  = {!stalled, !stalled, bt};
            e.fwd = {fsel(m_ex.rs), fsel(m_ex.rt)};
            q.push_back(e);
            m_wb  = m_mem;
            m_mem = m_ex;
            if (lu || bt) begin
                m_ex = nop();
                m_ex.rs = d.rs; m_ex.rt = d.rt; m_ex.rd = d.rd;
            end else begin
                m_ex = d;
            end
            if (stalled && m_sc < (1 << W) - 1)
                m_sc++;
        end
    endtask

    function automatic ins_t rnd_ins();
        ins_t i;
        i.regdst   = 1'($urandom);
        i.alusrc   = 1'($urandom);
        i.memtoreg = 1'($urandom);
        i.regwrite = 1'($urandom);
        i.memread  = 1'($urandom);
        i.memwrite = 1'($urandom);
        i.bne      = 1'($urandom);
        i.beq      = 1'($urandom);
        i.aluop    = 6'($urandom);
        i.rs       = 5'($urandom_range(0, 3));
        i.rt       = 5'($urandom_range(0, 3));
        i.rd       = 5'($urandom_range(0, 3));
        return i;
    endfunction

    initial begin
        ins_t rtype, lw8, lw0, use8, use0, wr5, rd5, cur;
        bit   st;
        m_ex = nop(); m_mem = nop(); m_wb = nop(); m_sc = 0;
        rtype = nop(); rtype.regdst = 1; rtype.regwrite = 1; rtype.rd = 9;
        rtype.rs = 10; rtype.rt = 11;
        lw8 = nop(); lw8.memread = 1; lw8.memtoreg = 1; lw8.regwrite = 1;
        lw8.alusrc = 1; lw8.rt = 8; lw8.rs = 1;
        lw0 = lw8; lw0.rt = 0;
        use8 = nop(); use8.regdst = 1; use8.regwrite = 1;
        use8.rs = 8; use8.rt = 2; use8.rd = 3;
        use0 = use8; use0.rs = 0;
        wr5 = nop(); wr5.regdst = 1; wr5.regwrite = 1; wr5.rd = 5;
        rd5 = nop(); rd5.rs = 5; rd5.rt = 5;

        step(nop(), 0, 1, st);
        step(rtype, 0, 0, st);
        repeat (3) step(nop(), 0, 0, st);
        step(lw8, 0, 0, st);
        step(use8, 0, 0, st);
        step(use8, 0, 0, st);
        repeat (3) step(nop(), 0, 0, st);
        step(lw0, 0, 0, st);
        step(use0, 0, 0, st);
        repeat (3) step(nop(), 0, 0, st);
        step(lw8, 0, 0, st);
        step(use8, 1, 0, st);
        step(nop(), 0, 0, st);
        step(wr5, 0, 0, st);
        step(wr5, 0, 0, st);
        step(rd5, 0, 0, st);
        step(nop(), 0, 0, st);
        repeat (2) step(nop(), 0, 0, st);
        repeat (6) begin
            step(lw8, 0, 0, st);
            step(use8, 0, 0, st);
            step(use8, 0, 0, st);
        end
        step(lw8, 0, 0, st);
        step(use8, 0, 1, st);
        step(use8, 0, 0, st);

        cur = rnd_ins();
        st = 0;
        for (int n = 0; n < 3000; n++) begin
            bit bt, rs;
            if (!st)
                cur = rnd_ins();
            bt = ($urandom_range(0, 7) == 0);
            rs = ($urandom_range(0, 99) == 0);
            step(cur, bt, rs, st);
        end

        for (int k = 0; k < 10 && q.size() > 0; k++)
            @(negedge clk);
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/control_pipe.md
# control_pipe

Carries the decoder's per-instruction control word from ID through the EX, MEM and WB pipeline registers of the pipelined MIPS core. It also generates the hazard controls that consume those signals:
- load-use stall,
- branch flush,
- EX-stage forwarding selects.

It sits between the opcode decoder (ID stage) and the datapath stage muxes, and keeps a saturating stall counter for performance checks.

## Interface
- STALL_CNT_WIDTH, 16, width of the saturating stall counter
- clk  in  1  system clock; all registers update on rising edge
- reset  in  1  asynchronous, active-high; clears every register
- RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, BranchNE, BranchEQ  in  1 each  ID-stage control from decoder
- ALUOp  in  6  ID-stage ALU opcode from decoder
- ID_Rs, ID_Rt, ID_Rd  in  5 each  register fields of instruction in ID
- BranchTaken  in  1  branch in EX resolved taken (combinational from EX datapath)
- PCWrite  out  1  PC load enable
- IFIDWrite  out  1  IF/ID register load enable
- IFIDFlush  out  1  clear IF/ID register on next edge
- EX_RegDst, EX_ALUSrc, EX_BranchNE, EX_BranchEQ  out  1 each  ID/EX stage control
- EX_ALUOp  out  6  ID/EX ALU opcode
- EX_Rs, EX_Rt  out  5 each  ID/EX source register fields
- MEM_MemRead, MEM_MemWrite  out  1 each  EX/MEM memory control
- MEM_WriteReg  out  5  EX/MEM destination register
- WB_RegWrite, WB_MemtoReg  out  1 each  MEM/WB writeback control
- WB_WriteReg  out  5  MEM/WB destination register
- ForwardA, ForwardB  out  2 each  EX ALU operand select: 00 register file, 10 EX/MEM result, 01 MEM/WB result
- StallCount  out  STALL_CNT_WIDTH  number of load-use stall cycles, saturating

## Operation

**Pipeline registers**
- Three stage registers: ID/EX, EX/MEM, MEM/WB.
- ID/EX holds all 14 control bits plus Rs, Rt, Rd.
- EX/MEM holds MemRead, MemWrite, MemtoReg, RegWrite, WriteReg.
- WriteReg = EX_RegDst ? EX_Rd : EX_Rt, computed in EX and registered into EX/MEM.
- MEM/WB holds RegWrite, MemtoReg, WriteReg.

**Bubble**
- All ID/EX control bits are 0.
- Register fields load normally; they are don't-care when control is 0.

**Load-use hazard**
- LoadUse = EX_MemRead & (EX_Rt != 0) & (EX_Rt == ID_Rs | EX_Rt == ID_Rt).
- ID_Rt is compared regardless of opcode; this is conservative and accepted.

**Stall (LoadUse=1, BranchTaken=0)**
- PCWrite=0, IFIDWrite=0, IFIDFlush=0.
- ID/EX loads a bubble.
- EX/MEM and MEM/WB advance normally.
- StallCount increments.

**Flush (BranchTaken=1)**
- PCWrite=1, IFIDWrite=1, IFIDFlush=1.
- ID/EX loads a bubble.
- LoadUse is ignored that cycle and StallCount does not increment; the branch has priority.

**Normal (otherwise)**
- PCWrite=1, IFIDWrite=1, IFIDFlush=0.
- ID/EX loads the decoder inputs.

**Forwarding**
- ForwardA = 10 if MEM_RegWrite & MEM_WriteReg != 0 & MEM_WriteReg == EX_Rs.
- Otherwise ForwardA = 01 if WB_RegWrite & WB_WriteReg != 0 & WB_WriteReg == EX_Rs.
- Otherwise ForwardA = 00.
- ForwardB uses the same rule with EX_Rt.
- EX/MEM always beats MEM/WB.
- MEM_RegWrite is the internal EX/MEM RegWrite bit.

**StallCount**
- Increments by 1 per stall cycle and saturates at all-ones; it never wraps.
- Cleared only by reset.

## Timing
- PCWrite, IFIDWrite, IFIDFlush, ForwardA and ForwardB are combinational from current register state plus inputs.
- All other outputs are registered.
- Latency: a decoder value presented in cycle n appears on EX_* after edge n+1, on MEM_* after n+2, and on WB_* after n+3.
- Load-use costs exactly one bubble:
  - cycle n: LoadUse=1.
  - edge n+1: the load moves to EX/MEM and ID/EX holds a bubble, so LoadUse drops.
  - the dependent instruction enters ID/EX at edge n+2 with ForwardX=01 from MEM/WB.
- Reset, asserted at any time including mid-stall: all registers 0, StallCount=0, all control outputs 0.
  - Combinational outputs under reset: PCWrite=1, IFIDWrite=1, IFIDFlush=0, ForwardA=ForwardB=00.
  - The first edge after deassertion loads ID/EX normally.
- Stall held across consecutive cycles: each cycle is counted and the pipeline front stays frozen.

## Test plan
- Load-use: lw writing $8 in EX (EX_MemRead=1, EX_Rt=8); ID_Rs=8 -> PCWrite=0, IFIDWrite=0; next edge EX_RegWrite=0, StallCount=1; following cycle PCWrite=1.
- Register $0: lw writing $0 in EX, ID_Rs=0 -> no stall, StallCount stays 0. WB_WriteReg=0 with WB_RegWrite=1 and EX_Rs=0 -> ForwardA=00.
- Forward priority: MEM_WriteReg=5 and WB_WriteReg=5, both RegWrite=1, EX_Rs=5, EX_Rt=5 -> ForwardA=10, ForwardB=10. Clear MEM RegWrite -> both 01.
- Branch over stall: BranchTaken=1 with LoadUse condition true -> PCWrite=1, IFIDFlush=1, next ID/EX all-zero control, StallCount unchanged.
- Latency: R-type word (RegDst=1, RegWrite=1, ALUOp=0), ID_Rd=9 -> EX_RegDst=1 after 1 edge, MEM_WriteReg=9 after 2, WB_RegWrite=1 and WB_WriteReg=9 after 3.
- Saturation and reset: STALL_CNT_WIDTH=2, hold LoadUse true for 5 cycles -> StallCount 1,2,3,3,3. Assert reset mid-stall -> StallCount=0 and all stage controls 0 immediately, without waiting for a clock edge.
